// File: rtl/pipe_sim_monitor.sv
// rtl/pipe_sim_monitor.sv - run-control monitor for the three-stage pipe core
//
// Purpose: watches the core for a stuck fetch PC, raised exceptions and
// out-of-range instruction/data memory accesses. The first terminating event
// is latched with its cause and address, the block drains for DRAIN_CYCLES
// edges, then holds done until reset.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous active-high reset
//   stall               core stall; freezes stuck counter, last PC, cycle count
//   inst_fetch_pc       current fetch PC
//   inst_mem_is_ready   instruction fetch request valid
//   inst_mem_address    instruction fetch address
//   dmem_write_ready    data write request valid
//   dmem_write_address  data write address
//   dmem_read_ready     data read request valid
//   dmem_read_address   data read address
//   exception           core exception flag
//   halt_req            high in DRAIN and HALT
//   done                high in HALT
//   done_cause          0 none, 1 imem, 2 dmem write, 3 dmem read, 4 exception, 5 timeout
//   fault_addr          offending address, or fetch PC for causes 4 and 5
//   cycle_count         non-stalled RUN cycles, wraps
module pipe_sim_monitor #(
  parameter int ADDR_W          = 32,
  parameter int IMEM_AW         = 12,
  parameter int DMEM_AW         = 12,
  parameter int TIMEOUT_CYCLES  = 100,
  parameter int CNT_W           = 8,
  parameter int DRAIN_CYCLES    = 1,
  parameter bit CHECK_DMEM_READ = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [ADDR_W-1:0] inst_fetch_pc,
  input  logic              inst_mem_is_ready,
  input  logic [ADDR_W-1:0] inst_mem_address,
  input  logic              dmem_write_ready,
  input  logic [ADDR_W-1:0] dmem_write_address,
  input  logic              dmem_read_ready,
  input  logic [ADDR_W-1:0] dmem_read_address,
  input  logic              exception,
  output logic              halt_req,
  output logic              done,
  output logic [2:0]        done_cause,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [31:0]       cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DRAIN_LAST  = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [CNT_W-1:0]  stuck_q, stuck_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [2:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] fault_q, fault_d;
  logic              halt_q, halt_d;
  logic              done_q, done_d;

  logic              imem_bad, dwr_bad, drd_bad;
  logic [2:0]        ev_cause;
  logic [ADDR_W-1:0] ev_addr;

  // An address is legal only when every bit above the memory size is zero.
  assign imem_bad = inst_mem_is_ready && ((inst_mem_address >> IMEM_AW) != '0);
  assign dwr_bad  = dmem_write_ready && ((dmem_write_address >> DMEM_AW) != '0);
  assign drd_bad  = CHECK_DMEM_READ && dmem_read_ready &&
                    ((dmem_read_address >> DMEM_AW) != '0);

  // Priority encode the candidate event; only consumed while in RUN.
  always_comb begin
    ev_cause = 3'd0;
    ev_addr  = '0;
    if (imem_bad) begin
      ev_cause = 3'd1;
      ev_addr  = inst_mem_address;
    end else if (dwr_bad) begin
      ev_cause = 3'd2;
      ev_addr  = dmem_write_address;
    end else if (drd_bad) begin
      ev_cause = 3'd3;
      ev_addr  = dmem_read_address;
    end else if (exception) begin
      ev_cause = 3'd4;
      ev_addr  = inst_fetch_pc;
    end else if (stuck_q > TIMEOUT_LIM) begin
      // Uses the registered count, so detection lags the count by one edge.
      ev_cause = 3'd5;
      ev_addr  = inst_fetch_pc;
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    stuck_d   = stuck_q;
    last_pc_d = last_pc_q;
    cycle_d   = cycle_q;
    cause_d   = cause_q;
    fault_d   = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (!stall) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          last_pc_d = inst_fetch_pc;
          if (inst_fetch_pc == last_pc_q)
            stuck_d = (stuck_q == STUCK_MAX) ? STUCK_MAX : stuck_q + 1'b1;
          else
            stuck_d = '0;
          cycle_d = cycle_q + 32'd1;
        end
        if (ev_cause != 3'd0) begin
          state_d = ST_DRAIN;
          drain_d = '0;
          cause_d = ev_cause;
          fault_d = ev_addr;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = ST_HALT;
        else                       drain_d = drain_q + 1'b1;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flag outputs follow the next state so they are true flops, not decodes.
    halt_d = (state_d == ST_DRAIN) || (state_d == ST_HALT);
    done_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      drain_q   <= '0;
      stuck_q   <= '0;
      last_pc_q <= '0;
      cycle_q   <= '0;
      cause_q   <= '0;
      fault_q   <= '0;
      halt_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      stuck_q   <= stuck_d;
      last_pc_q <= last_pc_d;
      cycle_q   <= cycle_d;
      cause_q   <= cause_d;
      fault_q   <= fault_d;
      halt_q    <= halt_d;
      done_q    <= done_d;
    end
  end

  assign halt_req    = halt_q;
  assign done        = done_q;
  assign done_cause  = cause_q;
  assign fault_addr  = fault_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_pipe_sim_monitor.sv
// tb/tb_pipe_sim_monitor.sv - self-checking bench for pipe_sim_monitor
module tb_pipe_sim_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, inst_mem_is_ready, dmem_write_ready, dmem_read_ready, exception;
  logic [31:0] inst_fetch_pc, inst_mem_address, dmem_write_address, dmem_read_address;

  logic        a_halt, a_done, n_halt, n_done, d_halt, d_done;
  logic [2:0]  a_cause, n_cause, d_cause;
  logic [31:0] a_fault, n_fault, d_fault, a_cyc, n_cyc, d_cyc;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_sim_monitor u_dut (
    .clk(clk), .reset(reset), .stall(stall), .inst_fetch_pc(inst_fetch_pc),
    .inst_mem_is_ready(inst_mem_is_ready), .inst_mem_address(inst_mem_address),
    .dmem_write_ready(dmem_write_ready), .dmem_write_address(dmem_write_address),
    .dmem_read_ready(dmem_read_ready), .dmem_read_address(dmem_read_address),
    .exception(exception), .halt_req(a_halt), .done(a_done),
    .done_cause(a_cause), .fault_addr(a_fault), .cycle_count(a_cyc));

  pipe_sim_monitor #(.CHECK_DMEM_READ(1'b0)) u_nr (
    .clk(clk), .reset(reset), .stall(stall), .inst_fetch_pc(inst_fetch_pc),
    .inst_mem_is_ready(inst_mem_is_ready), .inst_mem_address(inst_mem_address),
    .dmem_write_ready(dmem_write_ready), .dmem_write_address(dmem_write_address),
    .dmem_read_ready(dmem_read_ready), .dmem_read_address(dmem_read_address),
    .exception(exception), .halt_req(n_halt), .done(n_done),
    .done_cause(n_cause), .fault_addr(n_fault), .cycle_count(n_cyc));

  pipe_sim_monitor #(.DRAIN_CYCLES(4)) u_d4 (
    .clk(clk), .reset(reset), .stall(stall), .inst_fetch_pc(inst_fetch_pc),
    .inst_mem_is_ready(inst_mem_is_ready), .inst_mem_address(inst_mem_address),
    .dmem_write_ready(dmem_write_ready), .dmem_write_address(dmem_write_address),
    .dmem_read_ready(dmem_read_ready), .dmem_read_address(dmem_read_address),
    .exception(exception), .halt_req(d_halt), .done(d_done),
    .done_cause(d_cause), .fault_addr(d_fault), .cycle_count(d_cyc));

  // Reference model of the default-parameter instance, described as
  // "has the run started" and "how many edges ago did the first event happen".
  bit          m_started;
  int          m_age;
  int          m_cause;
  logic [31:0] m_addr;
  logic [31:0] m_cycles;
  int          m_stuck;
  logic [31:0] m_last;

  task automatic model_edge();
    int          c;
    logic [31:0] a;
    if (reset) begin
      m_started = 0; m_age = -1; m_cause = 0; m_addr = 0;
      m_cycles = 0; m_stuck = 0; m_last = 0;
    end else if (!m_started) begin
      if (!stall) m_started = 1;
    end else if (m_age >= 0) begin
      m_age++;
    end else begin
      c = 0; a = 0;
      if (inst_mem_is_ready && inst_mem_address >= 32'd4096) begin
        c = 1; a = inst_mem_address;
      end else if (dmem_write_ready && dmem_write_address >= 32'd4096) begin
        c = 2; a = dmem_write_address;
      end else if (dmem_read_ready && dmem_read_address >= 32'd4096) begin
        c = 3; a = dmem_read_address;
      end else if (exception) begin
        c = 4; a = inst_fetch_pc;
      end else if (m_stuck > 100) begin
        c = 5; a = inst_fetch_pc;
      end
      if (!stall) begin
        m_cycles = m_cycles + 1;
        if (inst_fetch_pc == m_last) m_stuck = (m_stuck < 255) ? m_stuck + 1 : 255;
        else                         m_stuck = 0;
        m_last = inst_fetch_pc;
      end
      if (c != 0) begin
        m_cause = c; m_addr = a; m_age = 0;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; inst_fetch_pc = 0; inst_mem_is_ready = 0; inst_mem_address = 0;
    dmem_write_ready = 0; dmem_write_address = 0; dmem_read_ready = 0;
    dmem_read_address = 0; exception = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; stall = 1;
    repeat (10) step();
    n_checks++;
    if ({a_halt, a_done, a_cause, a_fault, a_cyc} !== '0) begin
      n_fail++; $display("FAIL reset_dut: got halt=%b done=%b cause=%0d fault=%h cyc=%0d want all 0", a_halt, a_done, a_cause, a_fault, a_cyc);
    end
    n_checks++;
    if ({n_halt, n_done, n_cause, n_fault, n_cyc} !== '0) begin
      n_fail++; $display("FAIL reset_nr: got halt=%b done=%b cause=%0d want all 0", n_halt, n_done, n_cause);
    end
    n_checks++;
    if ({d_halt, d_done, d_cause, d_fault, d_cyc} !== '0) begin
      n_fail++; $display("FAIL reset_d4: got halt=%b done=%b cause=%0d want all 0", d_halt, d_done, d_cause);
    end
  endtask

  // Continues from test_reset: stall held through reset release, PC fixed at 0x40.
  task automatic test_timeout();
    reset = 0; inst_fetch_pc = 32'h40;
    repeat (5) step();
    n_checks++;
    if (a_halt !== 1'b0 || a_cyc !== 32'd0) begin
      n_fail++; $display("FAIL idle_stalled: got halt=%b cyc=%0d want 0 0", a_halt, a_cyc);
    end
    stall = 0;
    step();
    repeat (102) step();
    n_checks++;
    if (a_halt !== 1'b0 || a_cyc !== 32'd102) begin
      n_fail++; $display("FAIL timeout_early: got halt=%b cyc=%0d want 0 102", a_halt, a_cyc);
    end
    step();
    n_checks++;
    if (a_halt !== 1'b1 || a_done !== 1'b0) begin
      n_fail++; $display("FAIL timeout_halt: got halt=%b done=%b want 1 0", a_halt, a_done);
    end
    step();
    n_checks++;
    if (a_done !== 1'b1 || a_cause !== 3'd5 || a_fault !== 32'h40 || a_cyc !== 32'd103) begin
      n_fail++; $display("FAIL timeout_done: got done=%b cause=%0d fault=%h cyc=%0d want 1 5 00000040 103", a_done, a_cause, a_fault, a_cyc);
    end
    n_checks++;
    if (d_halt !== 1'b1 || d_done !== 1'b0) begin
      n_fail++; $display("FAIL timeout_d4_drain: got halt=%b done=%b want 1 0", d_halt, d_done);
    end
    repeat (3) step();
    n_checks++;
    if (d_done !== 1'b1 || d_cause !== 3'd5) begin
      n_fail++; $display("FAIL timeout_d4_done: got done=%b cause=%0d want 1 5", d_done, d_cause);
    end
  endtask

  task automatic test_imem_range();
    do_reset();
    inst_fetch_pc = 32'h100;
    step();
    for (int i = 0; i < 10; i++) begin
      inst_fetch_pc = inst_fetch_pc + 4;
      inst_mem_is_ready = 1;
      inst_mem_address = (i == 9) ? 32'hFFC : inst_fetch_pc;
      step();
    end
    n_checks++;
    if (a_halt !== 1'b0) begin
      n_fail++; $display("FAIL imem_inrange: got halt=%b want 0", a_halt);
    end
    inst_mem_address = 32'h1000;
    step();
    inst_mem_is_ready = 0;
    n_checks++;
    if (a_halt !== 1'b1 || a_cause !== 3'd1 || a_fault !== 32'h1000) begin
      n_fail++; $display("FAIL imem_event: got halt=%b cause=%0d fault=%h want 1 1 00001000", a_halt, a_cause, a_fault);
    end
    step();
    exception = 1; step();
    exception = 0; step();
    n_checks++;
    if (a_done !== 1'b1 || a_cause !== 3'd1 || a_fault !== 32'h1000) begin
      n_fail++; $display("FAIL imem_sticky: got done=%b cause=%0d fault=%h want 1 1 00001000", a_done, a_cause, a_fault);
    end
  endtask

  task automatic test_priority();
    do_reset();
    inst_fetch_pc = 32'h200;
    step();
    dmem_write_ready = 1; dmem_write_address = 32'hFFC;
    inst_fetch_pc = 32'h204; step();
    n_checks++;
    if (a_halt !== 1'b0) begin
      n_fail++; $display("FAIL dwr_inrange: got halt=%b want 0", a_halt);
    end
    dmem_write_address = 32'h2000; exception = 1;
    inst_fetch_pc = 32'h208; step();
    dmem_write_ready = 0; exception = 0;
    step();
    n_checks++;
    if (a_cause !== 3'd2 || a_fault !== 32'h2000 || n_cause !== 3'd2) begin
      n_fail++; $display("FAIL priority_dwr: got cause=%0d fault=%h nr_cause=%0d want 2 00002000 2", a_cause, a_fault, n_cause);
    end
  endtask

  task automatic test_dmem_read();
    do_reset();
    inst_fetch_pc = 32'h300;
    step();
    inst_fetch_pc = 32'h304;
    dmem_read_ready = 1; dmem_read_address = 32'hFFFC;
    step();
    dmem_read_ready = 0;
    n_checks++;
    if (a_halt !== 1'b1 || a_cause !== 3'd3 || a_fault !== 32'hFFFC) begin
      n_fail++; $display("FAIL dmem_read_on: got halt=%b cause=%0d fault=%h want 1 3 0000fffc", a_halt, a_cause, a_fault);
    end
    n_checks++;
    if (n_halt !== 1'b0 || n_cause !== 3'd0) begin
      n_fail++; $display("FAIL dmem_read_off: got halt=%b cause=%0d want 0 0", n_halt, n_cause);
    end
    inst_fetch_pc = 32'h344; exception = 1;
    step();
    exception = 0; step();
    n_checks++;
    if (n_done !== 1'b1 || n_cause !== 3'd4 || n_fault !== 32'h344) begin
      n_fail++; $display("FAIL dmem_read_off_exc: got done=%b cause=%0d fault=%h want 1 4 00000344", n_done, n_cause, n_fault);
    end
  endtask

  task automatic test_stall();
    do_reset();
    inst_fetch_pc = 32'h80;
    step();
    repeat (5) step();
    stall = 1;
    repeat (200) step();
    n_checks++;
    if (a_halt !== 1'b0 || a_cyc !== 32'd5) begin
      n_fail++; $display("FAIL stall_frozen: got halt=%b cyc=%0d want 0 5", a_halt, a_cyc);
    end
    stall = 0;
    repeat (97) step();
    n_checks++;
    if (a_halt !== 1'b0) begin
      n_fail++; $display("FAIL stall_release_early: got halt=%b want 0", a_halt);
    end
    step();
    n_checks++;
    if (a_halt !== 1'b1 || a_cyc !== 32'd103) begin
      n_fail++; $display("FAIL stall_release_fire: got halt=%b cyc=%0d want 1 103", a_halt, a_cyc);
    end
    step();
    n_checks++;
    if (a_done !== 1'b1 || a_cause !== 3'd5 || a_fault !== 32'h80) begin
      n_fail++; $display("FAIL stall_cause: got done=%b cause=%0d fault=%h want 1 5 00000080", a_done, a_cause, a_fault);
    end
  endtask

  task automatic test_drain_reset();
    do_reset();
    inst_fetch_pc = 32'h400;
    step();
    inst_mem_is_ready = 1; inst_mem_address = 32'h1000;
    step();
    inst_mem_is_ready = 0;
    step();
    n_checks++;
    if (d_halt !== 1'b1 || d_done !== 1'b0) begin
      n_fail++; $display("FAIL drain_mid: got halt=%b done=%b want 1 0", d_halt, d_done);
    end
    reset = 1;
    step();
    n_checks++;
    if ({d_halt, d_done, d_cause, d_fault, d_cyc} !== '0) begin
      n_fail++; $display("FAIL drain_reset: got halt=%b done=%b cause=%0d fault=%h cyc=%0d want all 0", d_halt, d_done, d_cause, d_fault, d_cyc);
    end
    reset = 0;
    step();
    for (int i = 0; i < 150; i++) begin
      inst_fetch_pc = 32'h200 + 32'(4 * i);
      step();
    end
    n_checks++;
    if (d_halt !== 1'b0 || d_done !== 1'b0 || d_cyc !== 32'd150) begin
      n_fail++; $display("FAIL drain_rerun: got halt=%b done=%b cyc=%0d want 0 0 150", d_halt, d_done, d_cyc);
    end
  endtask

  function automatic logic [31:0] rand_addr(bit bad);
    logic [31:0] a;
    a = $urandom;
    if (bad) begin
      if (a[31:12] == 20'd0) a[12] = 1'b1;
    end else begin
      a[31:12] = 20'd0;
    end
    return a;
  endfunction

  task automatic test_random();
    bit exp_halt, exp_done;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) == 0) || (m_age > 8 && $urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 4) inst_fetch_pc = {$urandom, 2'b00} & 32'hFFC;
      inst_mem_is_ready  = $urandom_range(0, 1);
      inst_mem_address   = rand_addr($urandom_range(0, 79) == 0);
      dmem_write_ready   = $urandom_range(0, 1);
      dmem_write_address = rand_addr($urandom_range(0, 79) == 0);
      dmem_read_ready    = $urandom_range(0, 1);
      dmem_read_address  = rand_addr($urandom_range(0, 79) == 0);
      exception          = ($urandom_range(0, 99) == 0);
      step();
      exp_halt = (m_age >= 0);
      exp_done = (m_age >= 1);
      n_checks++;
      if (a_halt !== exp_halt || a_done !== exp_done || a_cause !== 3'(m_cause) ||
          a_fault !== m_addr || a_cyc !== m_cycles) begin
        n_fail++;
        $display("FAIL random[%0d]: got halt=%b done=%b cause=%0d fault=%h cyc=%0d want %b %b %0d %h %0d",
                 i, a_halt, a_done, a_cause, a_fault, a_cyc, exp_halt, exp_done, m_cause, m_addr, m_cycles);
      end
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    m_started = 0; m_age = -1; m_cause = 0; m_addr = 0;
    m_cycles = 0; m_stuck = 0; m_last = 0;
    test_reset();
    test_timeout();
    test_imem_range();
    test_priority();
    test_dmem_read();
    test_stall();
    test_drain_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
